// File: rtl/key_conditioner.sv
// Six-key debouncer with press pulse, hold-delay auto-repeat and per-pair up/down lockout.
// Each key has a 2-flop synchronizer, a 5-state FSM and a shared-width cycle counter.
module key_conditioner #(
  parameter int unsigned DB_CYC      = 200,
  parameter int unsigned RPT_DLY_CYC = 5000,
  parameter int unsigned RPT_CYC     = 1000
) (
  input  logic       CP,
  input  logic       CR,
  input  logic [5:0] KEY,
  output logic [5:0] LEVEL,
  output logic [5:0] PULSE,
  output logic       BUSY
);

  localparam int unsigned MaxAB  = (DB_CYC > RPT_DLY_CYC) ? DB_CYC : RPT_DLY_CYC;
  localparam int unsigned MaxCyc = (MaxAB > RPT_CYC) ? MaxAB : RPT_CYC;
  localparam int unsigned CntW   = $clog2(MaxCyc + 1);

  localparam logic [CntW-1:0] DbCnt  = CntW'(DB_CYC);
  localparam logic [CntW-1:0] DlyCnt = CntW'(RPT_DLY_CYC);
  localparam logic [CntW-1:0] RptCnt = CntW'(RPT_CYC);
  localparam logic [CntW-1:0] OneCnt = CntW'(1);

  typedef enum logic [2:0] {StIdle, StDbPress, StHold, StRepeat, StDbRelease} state_e;

  logic [5:0] r_sync1;
  logic [5:0] r_sync2;
  logic [5:0] w_level;
  logic [5:0] w_pulse_raw;
  logic [5:0] w_lock;

  always_ff @(posedge CP or negedge CR) begin
    if (!CR) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
    end else begin
      r_sync1 <= KEY;
      r_sync2 <= r_sync1;
    end
  end

  for (genvar g = 0; g < 6; g++) begin : g_key
    state_e          r_state, w_state_d;
    logic [CntW-1:0] r_cnt, w_cnt_d;
    logic            r_pulse, w_pulse_d;
    logic            w_key;

    assign w_key = r_sync2[g];

    always_ff @(posedge CP or negedge CR) begin
      if (!CR) begin
        r_state <= StIdle;
        r_cnt   <= '0;
        r_pulse <= 1'b0;
      end else begin
        r_state <= w_state_d;
        r_cnt   <= w_cnt_d;
        r_pulse <= w_pulse_d;
      end
    end

    // Counter is reloaded on every transition, so it never needs to wrap.
    always_comb begin
      w_state_d = r_state;
      w_cnt_d   = r_cnt;
      w_pulse_d = 1'b0;
      unique case (r_state)
        StIdle: begin
          if (w_key) begin
            w_state_d = StDbPress;
            w_cnt_d   = OneCnt;
          end
        end
        StDbPress: begin
          if (!w_key) begin
            w_state_d = StIdle;
            w_cnt_d   = '0;
          end else if (r_cnt == DbCnt) begin
            w_state_d = StHold;
            w_cnt_d   = OneCnt;
            w_pulse_d = 1'b1;
          end else begin
            w_cnt_d = r_cnt + 1'b1;
          end
        end
        StHold: begin
          if (!w_key) begin
            w_state_d = StDbRelease;
            w_cnt_d   = OneCnt;
          end else if (r_cnt == DlyCnt) begin
            w_state_d = StRepeat;
            w_cnt_d   = OneCnt;
            w_pulse_d = 1'b1;
          end else begin
            w_cnt_d = r_cnt + 1'b1;
          end
        end
        StRepeat: begin
          if (!w_key) begin
            w_state_d = StDbRelease;
            w_cnt_d   = OneCnt;
          end else if (r_cnt == RptCnt) begin
            w_cnt_d   = OneCnt;
            w_pulse_d = 1'b1;
          end else begin
            w_cnt_d = r_cnt + 1'b1;
          end
        end
        StDbRelease: begin
          if (w_key) begin
            w_state_d = StHold;
            w_cnt_d   = OneCnt;
          end else if (r_cnt == DbCnt) begin
            w_state_d = StIdle;
            w_cnt_d   = '0;
          end else begin
            w_cnt_d = r_cnt + 1'b1;
          end
        end
        default: begin
          w_state_d = StIdle;
          w_cnt_d   = '0;
        end
      endcase
    end

    assign w_level[g]     = (r_state == StHold) || (r_state == StRepeat) ||
                            (r_state == StDbRelease);
    assign w_pulse_raw[g] = r_pulse;
  end

  // Both keys of an up/down pair held: suppress steps for the pair, repeats keep their grid.
  always_comb begin
    w_lock = {{2{w_level[5] & w_level[4]}},
              {2{w_level[3] & w_level[2]}},
              {2{w_level[1] & w_level[0]}}};
    LEVEL  = w_level;
    PULSE  = w_pulse_raw & ~w_lock;
    BUSY   = |w_level;
  end

endmodule

// File: tb/tb_key_conditioner.sv
// Directed bench for key_conditioner with DB_CYC=4, RPT_DLY_CYC=20, RPT_CYC=5.
// Cycle k is the state just after the k-th rising edge that samples the applied KEY.
module tb_key_conditioner;

  logic       CP;
  logic       CR;
  logic [5:0] KEY;
  logic [5:0] LEVEL;
  logic [5:0] PULSE;
  logic       BUSY;

  int total;
  int bad;

  key_conditioner #(
    .DB_CYC     (4),
    .RPT_DLY_CYC(20),
    .RPT_CYC    (5)
  ) dut (
    .CP   (CP),
    .CR   (CR),
    .KEY  (KEY),
    .LEVEL(LEVEL),
    .PULSE(PULSE),
    .BUSY (BUSY)
  );

  initial CP = 1'b0;
  always #5 CP = ~CP;

  task automatic tick();
    @(posedge CP);
    #1;
  endtask

  task automatic do_reset();
    KEY = '0;
    CR  = 1'b0;
    repeat (3) @(posedge CP);
    #1;
    CR = 1'b1;
  endtask

  task automatic test_reset();
    CR  = 1'b0;
    KEY = 6'h3f;
    #3;
    total++;
    if (LEVEL !== 6'h00) begin
      $display("FAIL reset_level got=%b want=%b", LEVEL, 6'h00); bad++;
    end
    total++;
    if (PULSE !== 6'h00) begin
      $display("FAIL reset_pulse got=%b want=%b", PULSE, 6'h00); bad++;
    end
    total++;
    if (BUSY !== 1'b0) begin
      $display("FAIL reset_busy got=%b want=%b", BUSY, 1'b0); bad++;
    end
    for (int k = 0; k < 10; k++) begin
      tick();
      total++;
      if ({LEVEL, PULSE, BUSY} !== 13'h0) begin
        $display("FAIL reset_held k=%0d got=%b want=0", k, {LEVEL, PULSE, BUSY}); bad++;
      end
    end
    KEY = '0;
    CR  = 1'b1;
  endtask

  task automatic test_press();
    logic [5:0] exp_p, exp_l;
    do_reset();
    KEY = 6'b000001;
    for (int k = 0; k <= 12; k++) begin
      tick();
      exp_p = (k == 6) ? 6'b000001 : 6'b000000;
      exp_l = (k >= 6) ? 6'b000001 : 6'b000000;
      total++;
      if (PULSE !== exp_p) begin
        $display("FAIL press_pulse k=%0d got=%b want=%b", k, PULSE, exp_p); bad++;
      end
      total++;
      if (LEVEL !== exp_l) begin
        $display("FAIL press_level k=%0d got=%b want=%b", k, LEVEL, exp_l); bad++;
      end
    end
  endtask

  task automatic test_bounce();
    do_reset();
    for (int k = 0; k < 20; k++) begin
      KEY = (k < 10 && (k % 2) == 0) ? 6'b000100 : 6'b000000;
      tick();
      total++;
      if ({LEVEL, PULSE} !== 12'h0) begin
        $display("FAIL bounce k=%0d got=%b want=0", k, {LEVEL, PULSE}); bad++;
      end
    end
  endtask

  task automatic test_repeat();
    logic [5:0] exp_p, exp_l;
    do_reset();
    for (int k = 0; k <= 55; k++) begin
      KEY = (k < 40) ? 6'b100000 : 6'b000000;
      tick();
      exp_p = (k == 6 || k == 26 || k == 31 || k == 36 || k == 41) ? 6'b100000 : 6'b000000;
      exp_l = (k >= 6 && k < 46) ? 6'b100000 : 6'b000000;
      total++;
      if (PULSE !== exp_p) begin
        $display("FAIL repeat_pulse k=%0d got=%b want=%b", k, PULSE, exp_p); bad++;
      end
      total++;
      if (LEVEL !== exp_l) begin
        $display("FAIL repeat_level k=%0d got=%b want=%b", k, LEVEL, exp_l); bad++;
      end
    end
  endtask

  task automatic test_lockout();
    logic [5:0] exp_p, exp_l;
    logic       exp_b;
    do_reset();
    for (int k = 0; k <= 50; k++) begin
      KEY = (k < 32) ? 6'b000011 : 6'b000001;
      tick();
      exp_p = (k == 41 || k == 46) ? 6'b000001 : 6'b000000;
      exp_l = {4'b0000, (k >= 6 && k < 38), (k >= 6)};
      exp_b = (k >= 6);
      total++;
      if (PULSE !== exp_p) begin
        $display("FAIL lockout_pulse k=%0d got=%b want=%b", k, PULSE, exp_p); bad++;
      end
      total++;
      if (LEVEL !== exp_l) begin
        $display("FAIL lockout_level k=%0d got=%b want=%b", k, LEVEL, exp_l); bad++;
      end
      total++;
      if (BUSY !== exp_b) begin
        $display("FAIL lockout_busy k=%0d got=%b want=%b", k, BUSY, exp_b); bad++;
      end
    end
  endtask

  task automatic test_independent();
    logic [5:0] exp_p;
    do_reset();
    KEY = 6'b010001;
    for (int k = 0; k <= 8; k++) begin
      tick();
      exp_p = (k == 6) ? 6'b010001 : 6'b000000;
      total++;
      if (PULSE !== exp_p) begin
        $display("FAIL indep_pulse k=%0d got=%b want=%b", k, PULSE, exp_p); bad++;
      end
    end
  endtask

  task automatic test_reset_mid();
    logic [5:0] exp_p, exp_l;
    do_reset();
    KEY = 6'b010000;
    for (int k = 0; k <= 14; k++) begin
      tick();
      exp_p = (k == 6) ? 6'b010000 : 6'b000000;
      exp_l = (k >= 6) ? 6'b010000 : 6'b000000;
      total++;
      if ({PULSE, LEVEL} !== {exp_p, exp_l}) begin
        $display("FAIL midrst_pre k=%0d got=%b want=%b", k, {PULSE, LEVEL}, {exp_p, exp_l});
        bad++;
      end
    end
    #2;
    CR = 1'b0;
    #1;
    total++;
    if ({LEVEL, PULSE, BUSY} !== 13'h0) begin
      $display("FAIL midrst_async got=%b want=0", {LEVEL, PULSE, BUSY}); bad++;
    end
    for (int k = 15; k <= 16; k++) begin
      tick();
      total++;
      if ({LEVEL, PULSE, BUSY} !== 13'h0) begin
        $display("FAIL midrst_held k=%0d got=%b want=0", k, {LEVEL, PULSE, BUSY}); bad++;
      end
    end
    CR = 1'b1;
    for (int k = 17; k <= 30; k++) begin
      tick();
      exp_p = (k == 23) ? 6'b010000 : 6'b000000;
      exp_l = (k >= 23) ? 6'b010000 : 6'b000000;
      total++;
      if (PULSE !== exp_p) begin
        $display("FAIL midrst_pulse k=%0d got=%b want=%b", k, PULSE, exp_p); bad++;
      end
      total++;
      if (LEVEL !== exp_l) begin
        $display("FAIL midrst_level k=%0d got=%b want=%b", k, LEVEL, exp_l); bad++;
      end
    end
  endtask

  initial begin
    total = 0;
    bad   = 0;
    CR    = 1'b0;
    KEY   = '0;
    test_reset();
    test_press();
    test_bounce();
    test_repeat();
    test_lockout();
    test_independent();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog time limit reached total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

endmodule

// File: doc/key_conditioner.md
KEY_CONDITIONER -- requirements
Module: key_conditioner

Interface
REQ-001 The block SHALL have parameter DB_CYC, default 200, the debounce length in CP cycles (20 ms at 10 kHz).
REQ-002 The block SHALL have parameter RPT_DLY_CYC, default 5000, the hold time in CP cycles before auto-repeat starts (500 ms).
REQ-003 The block SHALL have parameter RPT_CYC, default 1000, the auto-repeat period in CP cycles (100 ms).
REQ-004 CP  input  1  the single clock, driven by the 10 kHz scan/system clock; every flop SHALL be on its rising edge.
REQ-005 CR  input  1  reset: asynchronous assertion, active-low.
REQ-006 KEY  input  6  raw active-high buttons, bit order {SD,SU,MD,MU,HD,HU} = [5:0]; asynchronous to CP and bouncing.
REQ-007 LEVEL  output  6  debounced key state per bit.
REQ-008 PULSE  output  6  one-CP-cycle step request per bit, feeding the time-setting UP/DOWN inputs.
REQ-009 BUSY  output  1  high while any LEVEL bit is 1.

Function
REQ-010 Each KEY bit SHALL pass through a 2-flop synchronizer before any other logic uses it.
REQ-011 Each bit SHALL have its own 5-state FSM: IDLE, DB_PRESS, HOLD, REPEAT, DB_RELEASE.
REQ-012 IDLE -> DB_PRESS SHALL occur when the synchronized key is 1; the debounce counter loads 1.
REQ-013 In DB_PRESS the counter SHALL increment while the synchronized key is 1, and SHALL return to IDLE with the counter cleared on any 0.
REQ-014 When the counter reaches DB_CYC in DB_PRESS, the FSM SHALL go to HOLD, set LEVEL=1 and assert PULSE in that same cycle.
REQ-015 Press latency SHALL be exactly DB_CYC+2 CP cycles from the first edge sampling KEY=1 (stable) to PULSE=1.
REQ-016 In HOLD the counter SHALL count to RPT_DLY_CYC, then move to REPEAT and assert PULSE once.
REQ-017 In REPEAT, PULSE SHALL assert once every RPT_CYC cycles for as long as the key is held.
REQ-018 In HOLD or REPEAT, a synchronized 0 SHALL enter DB_RELEASE with the counter loaded 1, and no further PULSE SHALL occur.
REQ-019 In DB_RELEASE the counter SHALL increment while the key is 0, and a 1 SHALL return the FSM to HOLD with the repeat timing restarted.
REQ-020 When the counter reaches DB_CYC in DB_RELEASE, the FSM SHALL go to IDLE and clear LEVEL; no pulse SHALL be produced on release.
REQ-021 PULSE SHALL never be high for two consecutive cycles on any bit.
REQ-022 Pair lockout: pairs are (HU,HD), (MU,MD) and (SU,SD); while both LEVEL bits of a pair are 1, PULSE for both bits of that pair SHALL be forced to 0, including repeats.
REQ-023 When lockout ends, the remaining held key SHALL resume its repeat timing without an extra pulse.
REQ-024 Counters SHALL be wide enough for max(DB_CYC, RPT_DLY_CYC, RPT_CYC); wrap-around SHALL never occur because each counter is cleared on every state change.
REQ-025 Different pairs SHALL be fully independent, so simultaneous pulses on HU and SU are legal.

Reset
REQ-026 CR=0 SHALL asynchronously force all FSMs to IDLE and clear the synchronizers, counters, LEVEL=0, PULSE=0 and BUSY=0.
REQ-027 Reset asserted while a key is held SHALL produce no pulse on deassertion until a full DB_CYC debounce completes again.
REQ-028 Deassertion SHALL be synchronous to CP.

Verification (DB_CYC=4, RPT_DLY_CYC=20, RPT_CYC=5)
REQ-029 HU stable high from cycle 0 -> PULSE[0] high only at cycle 6, and LEVEL[0] rises at cycle 6.
REQ-030 MU toggling 1,0,1,0 each cycle for 10 cycles, then held 0 -> PULSE and LEVEL stay 0.
REQ-031 SD held 40 cycles -> PULSE[5] at cycles 6, 26 and 31, then every 5 cycles; after release, LEVEL[5] clears 6 cycles later with no further pulse.
REQ-032 HU and HD pressed together and held -> PULSE[1:0] stays 0 throughout, LEVEL[1:0]=2'b11 and BUSY=1.
REQ-033 Release HD while HU is still held -> HU repeats continue on its original grid, with no immediate pulse.
REQ-034 CR pulsed low at cycle 15 while SU is held -> all outputs clear immediately, and the next PULSE[4] fires 6 cycles after CR returns high.
